// File: rtl/wb_rambus_dma.sv
// wb_rambus_dma: Wishbone-programmed fill/checksum engine driving the OpenRAM rambus port B.
// Latency: CSR ack 1 cycle after strobe; first rambus strobe 1 cycle after the start ack; 2 cycles per beat minimum.
// Backpressure: each beat waits for rambus_wb_ack_i for up to TIMEOUT cycles, then the job ends with timeout_err.
// Optional build macro RAMBUS_DMA_IRQ_EN adds irq_o and CTRL bit 3 (irq_enable).
module wb_rambus_dma #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
`ifdef RAMBUS_DMA_IRQ_EN
  output logic        irq_o,
`endif
  output logic        rambus_wb_clk_o,
  output logic        rambus_wb_rst_o,
  output logic        rambus_wb_stb_o,
  output logic        rambus_wb_cyc_o,
  output logic        rambus_wb_we_o,
  output logic [3:0]  rambus_wb_sel_o,
  output logic [9:0]  rambus_wb_adr_o,
  output logic [31:0] rambus_wb_dat_o,
  input  logic        rambus_wb_ack_i,
  input  logic [31:0] rambus_wb_dat_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACC, S_DONE} state_t;

  state_t      state;
  logic [7:0]  base_r;
  logic [8:0]  len_r;
  logic [31:0] pattern_r;
  logic [31:0] result_r;
  logic        st_done, st_err, st_abort;
  logic        start_q, start_mode_q, abort_q;
  logic        mode_l;
  logic [7:0]  base_l;
  logic [8:0]  len_l;
  logic [31:0] pat_l;
  logic [8:0]  idx;
  logic [8:0]  idx_n;
  logic [7:0]  wcnt;
  logic [7:0]  word_adr;
  logic [31:0] cap_dat;
  logic        abort_pend;
  logic        busy;
  logic        hit, access, wr, rd;
  logic [2:0]  reg_sel;
  logic [2:0]  status_clr;
  logic [31:0] rdata;
`ifdef RAMBUS_DMA_IRQ_EN
  logic        irq_en;
`endif

  // Byte enables, the low address bits and the aliased upper window bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[7:5], wbs_adr_i[1:0]};

  assign rambus_wb_clk_o = wb_clk_i;
  assign rambus_wb_rst_o = wb_rst_i;
  assign rambus_wb_sel_o = 4'hF;
  assign rambus_wb_adr_o = {word_adr, 2'b00};

  assign busy    = (state != S_IDLE);
  assign hit     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // The cycle after an ack never acks again, so a held strobe is served once per two cycles.
  assign access  = hit & ~wbs_ack_o;
  assign wr      = access & wbs_we_i;
  assign rd      = access & ~wbs_we_i;
  assign reg_sel = wbs_adr_i[4:2];
  assign idx_n   = idx + 9'd1;
  // W1C mask for {aborted, timeout_err, done}; hardware sets in the FSM override it.
  assign status_clr = (wr && reg_sel == 3'd1) ? wbs_dat_i[3:1] : 3'b000;

  // CSR read mux.
  always_comb begin
    rdata = 32'd0;
    case (reg_sel)
`ifdef RAMBUS_DMA_IRQ_EN
      3'd0: rdata = {28'd0, irq_en, 3'd0};
`endif
      3'd1: rdata = {28'd0, st_abort, st_err, st_done, busy};
      3'd2: rdata = {24'd0, base_r};
      3'd3: rdata = {23'd0, len_r};
      3'd4: rdata = pattern_r;
      3'd5: rdata = result_r;
      default: rdata = 32'd0;
    endcase
  end

  // CSR slave: ack, registered read data, writable registers and one-cycle command pulses.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= 32'd0;
      base_r       <= 8'd0;
      len_r        <= 9'd0;
      pattern_r    <= 32'd0;
      start_q      <= 1'b0;
      start_mode_q <= 1'b0;
      abort_q      <= 1'b0;
`ifdef RAMBUS_DMA_IRQ_EN
      irq_en       <= 1'b0;
`endif
    end else begin
      wbs_ack_o    <= access;
      wbs_dat_o    <= rd ? rdata : 32'd0;
      start_q      <= wr && (reg_sel == 3'd0) && wbs_dat_i[0];
      start_mode_q <= wbs_dat_i[1];
      abort_q      <= wr && (reg_sel == 3'd0) && wbs_dat_i[2];
      if (wr) begin
        case (reg_sel)
`ifdef RAMBUS_DMA_IRQ_EN
          3'd0: irq_en <= wbs_dat_i[3];
`endif
          3'd2: base_r    <= wbs_dat_i[7:0];
          3'd3: len_r     <= (wbs_dat_i > 32'd256) ? 9'd256 : wbs_dat_i[8:0];
          3'd4: pattern_r <= wbs_dat_i;
          default: ;
        endcase
      end
    end
  end

  // Transfer FSM with registered rambus outputs, status flags and checksum accumulator.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state           <= S_IDLE;
      rambus_wb_cyc_o <= 1'b0;
      rambus_wb_stb_o <= 1'b0;
      rambus_wb_we_o  <= 1'b0;
      rambus_wb_dat_o <= 32'd0;
      word_adr        <= 8'd0;
      idx             <= 9'd0;
      wcnt            <= 8'd0;
      mode_l          <= 1'b0;
      base_l          <= 8'd0;
      len_l           <= 9'd0;
      pat_l           <= 32'd0;
      cap_dat         <= 32'd0;
      result_r        <= 32'd0;
      st_done         <= 1'b0;
      st_err          <= 1'b0;
      st_abort        <= 1'b0;
      abort_pend      <= 1'b0;
    end else begin
      st_done  <= st_done  & ~status_clr[0];
      st_err   <= st_err   & ~status_clr[1];
      st_abort <= st_abort & ~status_clr[2];
      if (abort_q && busy) abort_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          abort_pend <= 1'b0;
          if (start_q) begin
            mode_l   <= start_mode_q;
            base_l   <= base_r;
            len_l    <= len_r;
            pat_l    <= pattern_r;
            st_done  <= 1'b0;
            st_err   <= 1'b0;
            st_abort <= 1'b0;
            result_r <= 32'd0;
            idx      <= 9'd0;
            if (len_r == 9'd0) begin
              state <= S_DONE;
            end else begin
              state           <= S_REQ;
              rambus_wb_cyc_o <= 1'b1;
              rambus_wb_stb_o <= 1'b1;
              rambus_wb_we_o  <= ~start_mode_q;
              word_adr        <= base_r;
              rambus_wb_dat_o <= pattern_r;
              wcnt            <= 8'd0;
            end
          end
        end
        S_REQ: begin
          if (rambus_wb_ack_i) begin
            cap_dat         <= rambus_wb_dat_i;
            rambus_wb_cyc_o <= 1'b0;
            rambus_wb_stb_o <= 1'b0;
            state           <= S_ACC;
          end else if (wcnt == 8'(TIMEOUT - 1)) begin
            rambus_wb_cyc_o <= 1'b0;
            rambus_wb_stb_o <= 1'b0;
            st_err          <= 1'b1;
            state           <= S_IDLE;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        S_ACC: begin
          if (mode_l) result_r <= result_r + cap_dat;
          idx <= idx_n;
          if (idx_n == len_l) begin
            state <= S_DONE;
          end else if (abort_pend || abort_q) begin
            st_abort <= 1'b1;
            state    <= S_IDLE;
          end else begin
            state           <= S_REQ;
            rambus_wb_cyc_o <= 1'b1;
            rambus_wb_stb_o <= 1'b1;
            word_adr        <= base_l + idx_n[7:0];
            rambus_wb_dat_o <= pat_l + {23'd0, idx_n};
            wcnt            <= 8'd0;
          end
        end
        S_DONE: begin
          st_done <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RAMBUS_DMA_IRQ_EN
  // Interrupt: completion or timeout, gated by irq_enable.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) irq_o <= 1'b0;
    else          irq_o <= irq_en & (st_done | st_err);
  end
`endif

endmodule
